serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Port: clk  input  1  single clock for all state; rising-edge triggered.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: A  input  W  operand A, sampled on acceptance.
REQ-005 Port: B  input  W  operand B, sampled on acceptance.
REQ-006 Port: CI  input  1  carry-in, sampled on acceptance, used when SUB=0.
REQ-007 Port: SUB  input  1  1 = compute A-B, sampled on acceptance.
REQ-008 Port: in_valid  input  1  request valid.
REQ-009 Port: in_ready  output  1  block can accept a request.
REQ-010 Port: SUM  output  W  result.
REQ-011 Port: CO  output  1  final carry-out; for SUB, 1 = no borrow.
REQ-012 Port: out_valid  output  1  SUM/CO valid.
REQ-013 Port: out_ready  input  1  consumer takes result.
REQ-014 Port: busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: in_valid=1 at a rising edge captures A, B (B inverted if SUB), carry = SUB ? 1 : CI, clears slice counter, goes to RUN.
REQ-017 RUN: exactly one shared 4-bit ripple adder instance, fed with nibble k of captured A/B and the carry register; each cycle writes nibble k of SUM, updates carry, increments k.
REQ-018 Nibbles processed least-significant first, k = 0..NIBBLES-1; at k = NIBBLES-1 the FSM enters DONE and CO takes the final carry.
REQ-019 Latency: out_valid rises exactly NIBBLES cycles after the acceptance edge.
REQ-020 DONE: SUM and CO held stable until out_ready=1 at a rising edge, then FSM returns to IDLE; next request accepted no earlier than the following edge.
REQ-021 in_valid ignored outside IDLE; input changes during RUN/DONE do not affect the result in flight.
REQ-022 out_ready ignored outside DONE.
REQ-023 Arithmetic modulo 2^W; wrap-around reported only via CO (and OVF when compiled in).
REQ-024 SUM bits of nibbles not yet processed in RUN are don't-care; only values under out_valid=1 are checked.

Reset
REQ-025 rst_n low forces, without a clock edge: state IDLE, in_ready 1, out_valid 0, busy 0, SUM 0, CO 0, carry 0, counter 0.
REQ-026 Reset asserted mid-RUN or in DONE aborts the operation; the result is discarded; no out_valid follows after release.
REQ-027 First request accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: extra output OVF (1 bit) = two's-complement signed overflow of the W-bit operation, valid under out_valid, reset 0.
REQ-029 Macro undefined: OVF port and its logic absent; all other behaviour identical.

Verification
REQ-030 NIBBLES=4, A=0x1234, B=0x0FFF, CI=0, SUB=0 -> SUM=0x2233, CO=0, out_valid exactly 4 cycles after accept.
REQ-031 A=0xFFFF, B=0x0001, CI=0 -> SUM=0x0000, CO=1; with CI=1, A=0xFFFF, B=0x0000 -> SUM=0x0000, CO=1.
REQ-032 SUB=1, A=0x0005, B=0x0007 -> SUM=0xFFFE, CO=0; SUB=1, A=0x0007, B=0x0005 -> SUM=0x0002, CO=1.
REQ-033 out_ready held 0 for 10 cycles in DONE -> SUM/CO/out_valid stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst_n pulsed low at RUN cycle 2 -> immediate in_ready=1, out_valid=0, SUM=0; no spurious out_valid; new request completes correctly.
REQ-035 SERIAL_ADD_OVF_EN defined: A=0x7FFF, B=0x0001 -> SUM=0x8000, OVF=1, CO=0; SUB=1, A=0x8000, B=0x0001 -> SUM=0x7FFF, OVF=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple adder walks the operands LSB nibble first.
// Optional signed-overflow output OVF is compiled in when SERIAL_ADD_OVF_EN is defined.

module serial_add_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin
    logic carry;
    // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 CI,
  input  logic                 SUB,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 CO,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                 OVF
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [CW-1:0] count;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    nib_sum;
  logic          nib_cout;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (count == CW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  serial_add_nibble u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      // NOTE: operand registers are reset too; they are few flops and make post-reset state fully defined.
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      count     <= '0;
      SUM       <= '0;
      CO        <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      OVF       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= SUB ? ~B : B;
            carry    <= SUB ? 1'b1 : CI;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (count == CW'(i)) SUM[4*i +: 4] <= nib_sum;
          end
          carry <= nib_cout;
          count <= count + 1'b1;
          if (count == LAST) begin
            CO        <= nib_cout;
`ifdef SERIAL_ADD_OVF_EN
            // Signed overflow: operand signs agree but the result sign differs.
            OVF       <= (a_nib[3] == b_nib[3]) && (nib_sum[3] != a_nib[3]);
`endif
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (NIBBLES=4); OVF vectors run when SERIAL_ADD_OVF_EN is defined.

module tb_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .CI        (ci),
    .SUB       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SUM       (sum),
    .CO        (co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .OVF       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request once in_ready is seen; returns 1 ns after the accepting edge with inputs scrambled.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci, input logic tsub);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("accept_timeout", 32'(t), 0);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = ~tci; sub = ~tsub;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), NIBBLES);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tci, input logic tsub, input logic [W-1:0] exp_sum, input logic exp_co);
    start_op(ta, tb, tci, tsub);
    wait_done(tag);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_co"}, 32'(co), 32'(exp_co));
    finish_op(tag);
  endtask

  initial begin
    int bad;
    rst_n = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("reset_sum_co", {15'd0, co, sum}, 32'd0);

    // Request already pending while reset releases: accepted on the very first edge.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("first_accept_busy", {30'd0, busy, in_ready}, 32'b10);
    wait_done("wrap_add");
    check("wrap_add_sum", 32'(sum), 32'h0000);
    check("wrap_add_co", 32'(co), 32'd1);
    finish_op("wrap_add");

    do_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
    do_op("add_cin",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    do_op("add_alt",   16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1);
    do_op("add_msb",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_op("add_small", 16'h0102, 16'h0304, 1'b1, 1'b0, 16'h0407, 1'b0);
    do_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    do_op("sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    do_op("sub_zero",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1);

    // Result held in DONE while the consumer stalls; new requests must be ignored.
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    wait_done("hold");
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); ci = 1'b1; sub = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (sum !== 16'h2233 || co !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    check("hold_stable", 32'(bad), 0);
    finish_op("hold");

    // Reset in the middle of RUN aborts the operation.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("abort_sum_co", {15'd0, co, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_valid", 32'(bad), 0);
    do_op("after_abort", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("ovf_add");
    check("ovf_add_sum", 32'(sum), 32'h8000);
    check("ovf_add_ovf", 32'(ovf), 32'd1);
    check("ovf_add_co", 32'(co), 32'd0);
    finish_op("ovf_add");
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done("ovf_sub");
    check("ovf_sub_sum", 32'(sum), 32'h7FFF);
    check("ovf_sub_ovf", 32'(ovf), 32'd1);
    finish_op("ovf_sub");
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    wait_done("ovf_none");
    check("ovf_none_ovf", 32'(ovf), 32'd0);
    finish_op("ovf_none");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
